brv_gen: RTL and testbench



---
 rtl/brv_pkg.sv | 20 ++
 rtl/brv_lfsr.sv | 41 ++++
 rtl/brv_gen.sv | 139 +++++++++++++
 tb/tb_brv_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brv_pkg.sv
// Shared types and constants for the Bernoulli random variable generator.
package brv_pkg;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int IDX_CAPTURE = 0;
  localparam int IDX_MINUS   = 1;
  localparam int IDX_SEARCH  = 2;
  localparam int IDX_BACKOFF = 3;
  localparam int IDX_MIN     = 4;
  localparam int IDX_F0      = 5;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    COMMIT
  } brv_state_e;

endpackage

// File: rtl/brv_lfsr.sv
// 16-bit right-shift Galois LFSR with step enable and zero-lockup guard; 1-cycle update.
// Optional BRV_GEN_SEED_LOAD_EN adds a synchronous seed load; no backpressure.
module brv_lfsr
  import brv_pkg::*;
#(
  parameter int          PRES = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
`ifdef BRV_GEN_SEED_LOAD_EN
  input  logic            seed_load,
  input  logic [15:0]     seed_in,
`endif
  output logic [PRES-1:0] sample
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    lfsr_d   = lfsr_q;
    if (step) begin
      lfsr_d = (lfsr_nxt == '0) ? SEED : lfsr_nxt;
    end
`ifdef BRV_GEN_SEED_LOAD_EN
    else if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign sample = lfsr_q[PRES-1:0];

endmodule

// File: rtl/brv_gen.sv
// Draws one BRV set per gamma pulse (one bit per cycle) and commits it atomically NB+1 cycles later.
// No backpressure: a gamma pulse arriving mid-draw is dropped and flags sticky overrun. Option: BRV_GEN_SEED_LOAD_EN.
module brv_gen
  import brv_pkg::*;
#(
  parameter int          WRES = 3,
  parameter int          PRES = 8,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int         FW   = (1 << WRES) - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               grst,
  input  logic [PRES-1:0]    thr_capture,
  input  logic [PRES-1:0]    thr_minus,
  input  logic [PRES-1:0]    thr_search,
  input  logic [PRES-1:0]    thr_backoff,
  input  logic [PRES-1:0]    thr_min,
  input  logic [FW*PRES-1:0] f_thr,
`ifdef BRV_GEN_SEED_LOAD_EN
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
`endif
  output logic               capture_brv,
  output logic               minus_brv,
  output logic               search_brv,
  output logic               backoff_brv,
  output logic               min_brv,
  output logic [FW-1:0]      F_brv,
  output logic               brv_valid,
  output logic               commit,
  output logic               overrun
);

  localparam int NB = IDX_F0 + FW;
  localparam int IW = $clog2(NB);

  brv_state_e                state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NB-1:0][PRES-1:0]   thr_q, thr_d;
  logic [NB-1:0]             shadow_q, shadow_d;
  logic [NB-1:0]             out_q, out_d;
  logic                      brv_valid_q, brv_valid_d;
  logic                      commit_q, commit_d;
  logic                      overrun_q, overrun_d;
  logic                      lfsr_step;
  logic                      seed_go;
  logic [PRES-1:0]           sample;

`ifdef BRV_GEN_SEED_LOAD_EN
  assign seed_go = seed_load && (state_q == IDLE);
`else
  assign seed_go = 1'b0;
`endif

  brv_lfsr #(
    .PRES (PRES),
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .step      (lfsr_step),
`ifdef BRV_GEN_SEED_LOAD_EN
    .seed_load (seed_go),
    .seed_in   (seed_in),
`endif
    .sample    (sample)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    thr_d       = thr_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    brv_valid_d = brv_valid_q;
    commit_d    = 1'b0;
    overrun_d   = overrun_q;
    lfsr_step   = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous seed load takes the cycle; the gamma pulse is dropped silently.
        if (grst && !seed_go) begin
          thr_d   = {f_thr, thr_min, thr_backoff, thr_search, thr_minus, thr_capture};
          idx_d   = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        shadow_d[idx_q] = (sample < thr_q[idx_q]);
        lfsr_step       = 1'b1;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IW'(NB - 1)) state_d = COMMIT;
        if (grst) overrun_d = 1'b1;
      end
      COMMIT: begin
        out_d       = shadow_q;
        commit_d    = 1'b1;
        brv_valid_d = 1'b1;
        state_d     = IDLE;
        if (grst) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      thr_q       <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      brv_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      thr_q       <= thr_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      brv_valid_q <= brv_valid_d;
      commit_q    <= commit_d;
      overrun_q   <= overrun_d;
    end
  end

  assign capture_brv = out_q[IDX_CAPTURE];
  assign minus_brv   = out_q[IDX_MINUS];
  assign search_brv  = out_q[IDX_SEARCH];
  assign backoff_brv = out_q[IDX_BACKOFF];
  assign min_brv     = out_q[IDX_MIN];
  assign F_brv       = out_q[IDX_F0 +: FW];
  assign brv_valid   = brv_valid_q;
  assign commit      = commit_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_brv_gen.sv
// Directed bench for brv_gen: latency, threshold boundaries, latch stability, overrun, reset, statistics.
module tb_brv_gen;

  localparam int NB = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        grst = 1'b0;
  logic [7:0]  thr_capture = '0, thr_minus = '0, thr_search = '0, thr_backoff = '0, thr_min = '0;
  logic [47:0] f_thr = '0;
  logic        capture_brv, minus_brv, search_brv, backoff_brv, min_brv;
  logic [5:0]  F_brv;
  logic        brv_valid, commit, overrun;
`ifdef BRV_GEN_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brv_gen dut (
    .clk         (clk),
    .rst         (rst),
    .grst        (grst),
    .thr_capture (thr_capture),
    .thr_minus   (thr_minus),
    .thr_search  (thr_search),
    .thr_backoff (thr_backoff),
    .thr_min     (thr_min),
    .f_thr       (f_thr),
`ifdef BRV_GEN_SEED_LOAD_EN
    .seed_load   (seed_load),
    .seed_in     (seed_in),
`endif
    .capture_brv (capture_brv),
    .minus_brv   (minus_brv),
    .search_brv  (search_brv),
    .backoff_brv (backoff_brv),
    .min_brv     (min_brv),
    .F_brv       (F_brv),
    .brv_valid   (brv_valid),
    .commit      (commit),
    .overrun     (overrun)
  );

  function automatic logic [10:0] brv_vec();
    return {F_brv, min_brv, backoff_brv, search_brv, minus_brv, capture_brv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] thr_arr [NB];

  task automatic apply_thr();
    thr_capture = thr_arr[0];
    thr_minus   = thr_arr[1];
    thr_search  = thr_arr[2];
    thr_backoff = thr_arr[3];
    thr_min     = thr_arr[4];
    for (int i = 0; i < 6; i++) f_thr[i*8 +: 8] = thr_arr[5+i];
  endtask

  task automatic fill_thr(input logic [7:0] v);
    for (int i = 0; i < NB; i++) thr_arr[i] = v;
    apply_thr();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    grst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where commit is high (lat = cycles after grst).
  task automatic gamma(output int lat);
    lat  = -1;
    grst = 1'b1;
    @(negedge clk);
    grst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (commit) begin
        lat = n;
        break;
      end
    end
  endtask

  // Reference LFSR and draw model.
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] x);
    logic [15:0] n;
    n = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    return (n == 16'h0) ? 16'hACE1 : n;
  endfunction

  function automatic logic [10:0] model_draw();
    logic [10:0] v;
    for (int i = 0; i < NB; i++) begin
      v[i]   = (m_lfsr[7:0] < thr_arr[i]);
      m_lfsr = lstep(m_lfsr);
    end
    return v;
  endfunction

  // First-draw samples after reset are E1 70 38 9C 4E 27 13 89 C4 62 B1.
  task automatic set_directed();
    thr_arr[0] = 8'hE2; thr_arr[1] = 8'h70; thr_arr[2]  = 8'h39; thr_arr[3] = 8'h9C;
    thr_arr[4] = 8'h4F; thr_arr[5] = 8'h28; thr_arr[6]  = 8'h13; thr_arr[7] = 8'h8A;
    thr_arr[8] = 8'hC4; thr_arr[9] = 8'h63; thr_arr[10] = 8'hB1;
    apply_thr();
  endtask

  initial begin
    int lat;
    int n;
    int ones;
    logic [10:0] exp_v;

    // Reset state
    do_reset();
    chk("rst_brv", 32'(brv_vec()), 32'h0);
    chk("rst_valid", 32'(brv_valid), 32'h0);
    chk("rst_commit", 32'(commit), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // Threshold 0 everywhere: never 1; latency 12
    fill_thr(8'h00);
    gamma(lat);
    chk("thr0_latency", 32'(lat), 32'd12);
    chk("thr0_brv", 32'(brv_vec()), 32'h0);
    chk("thr0_valid", 32'(brv_valid), 32'h1);
    @(negedge clk);
    chk("commit_pulse", 32'(commit), 32'h0);

    // Capture sample E1: threshold E1 gives 0, E2 gives 1
    do_reset();
    fill_thr(8'h00);
    thr_arr[0] = 8'hE1;
    apply_thr();
    gamma(lat);
    chk("cap_eq_thr", 32'(brv_vec()), 32'h0);
    do_reset();
    thr_arr[0] = 8'hE2;
    apply_thr();
    gamma(lat);
    chk("cap_gt_thr", 32'(brv_vec()), 32'h1);

    // All-ones thresholds: every first-draw sample is below FF
    do_reset();
    fill_thr(8'hFF);
    gamma(lat);
    chk("thr_ff_brv", 32'(brv_vec()), 32'h7FF);

    // Directed pattern; thresholds cleared right after grst must not tear the draw
    do_reset();
    set_directed();
    grst = 1'b1;
    @(negedge clk);
    grst = 1'b0;
    fill_thr(8'h00);
    lat = -1;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (commit) begin
        lat = n;
        break;
      end
    end
    chk("dir_latency", 32'(lat), 32'd12);
    chk("dir_brv", 32'(brv_vec()), 32'h2B5);

    // Reset 5 cycles into the next draw
    set_directed();
    grst = 1'b1;
    @(negedge clk);
    grst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_brv", 32'(brv_vec()), 32'h0);
    chk("midrst_valid", 32'(brv_valid), 32'h0);
    chk("midrst_commit", 32'(commit), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    gamma(lat);
    chk("midrst_redraw_lat", 32'(lat), 32'd12);
    chk("midrst_redraw_brv", 32'(brv_vec()), 32'h2B5);

    // Overrun: extra grst at cycle 3 is ignored but flagged
    do_reset();
    set_directed();
    grst = 1'b1;
    @(negedge clk);
    grst = 1'b0;
    @(negedge clk);
    chk("ovr_before", 32'(overrun), 32'h0);
    grst = 1'b1;
    @(negedge clk);
    grst = 1'b0;
    chk("ovr_set", 32'(overrun), 32'h1);
    lat = -1;
    for (n = 3; n <= 30; n++) begin
      @(negedge clk);
      if (commit) begin
        lat = n;
        break;
      end
    end
    chk("ovr_latency", 32'(lat), 32'd12);
    chk("ovr_brv", 32'(brv_vec()), 32'h2B5);
    ones = 0;
    repeat (25) begin
      @(negedge clk);
      if (commit) ones++;
    end
    chk("ovr_no_redraw", 32'(ones), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'h1);

`ifdef BRV_GEN_SEED_LOAD_EN
    // Zero seed falls back to SEED
    do_reset();
    fill_thr(8'h00);
    thr_arr[0] = 8'hE2;
    apply_thr();
    gamma(lat);
    seed_in = 16'h0000; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    gamma(lat);
    chk("seed0_cap", 32'(brv_vec()), 32'h1);
    // Seed 1234: first sample 34
    thr_arr[0] = 8'h35;
    apply_thr();
    seed_in = 16'h1234; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    gamma(lat);
    chk("seed1234_cap_hi", 32'(brv_vec()), 32'h1);
    thr_arr[0] = 8'h34;
    apply_thr();
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    gamma(lat);
    chk("seed1234_cap_eq", 32'(brv_vec()), 32'h0);
    // Seed load with grst: no draw, no overrun
    seed_load = 1'b1; grst = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; grst = 1'b0;
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      if (commit) ones++;
    end
    chk("seedgrst_no_draw", 32'(ones), 32'd0);
    chk("seedgrst_no_ovr", 32'(overrun), 32'h0);
`endif

    // Statistics: search at 64/256, everything else bit-exact against the model
    do_reset();
    for (int i = 0; i < NB; i++) thr_arr[i] = 8'(32 * (i % 8) + 17);
    thr_arr[2] = 8'd64;
    apply_thr();
    m_lfsr = 16'hACE1;
    ones = 0;
    for (int g = 0; g < 4096; g++) begin
      exp_v = model_draw();
      gamma(lat);
      if (lat != 12) chk("stat_latency", 32'(lat), 32'd12);
      chk("stat_brv", 32'(brv_vec()), 32'(exp_v));
      if (search_brv) ones++;
    end
    chk("stat_search_rate", 32'((ones >= 942) && (ones <= 1106)), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
